// File: rtl/comparer_pkg.sv
// Condition encodings, registered flag bundle and the ctrl/flag decode shared by
// the comparer_pipe datapath.
package comparer_pkg;

    localparam logic [2:0] CMP_NEQ = 3'b000;
    localparam logic [2:0] CMP_EQ  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b010;
    localparam logic [2:0] CMP_LTU = 3'b011;
    localparam logic [2:0] CMP_LTZ = 3'b100;
    localparam logic [2:0] CMP_GEZ = 3'b101;
    localparam logic [2:0] CMP_LEZ = 3'b110;
    localparam logic [2:0] CMP_GTZ = 3'b111;

    typedef struct packed {
        logic eq;
        logic slt;
        logic ult;
        logic az;
        logic an;
    } cmp_flags_t;

    // Returns {cond, illegal}; the default arm is where a widened ctrl would land.
    function automatic logic [1:0] cmp_decode(input logic [2:0] ctrl, input cmp_flags_t f);
        logic cond;
        logic illegal;
        cond    = 1'b0;
        illegal = 1'b0;
        case (ctrl)
            CMP_NEQ: cond = ~f.eq;
            CMP_EQ:  cond = f.eq;
            CMP_LT:  cond = f.slt;
            CMP_LTU: cond = f.ult;
            CMP_LTZ: cond = f.an;
            CMP_GEZ: cond = ~f.an;
            CMP_LEZ: cond = f.an | f.az;
            CMP_GTZ: cond = ~f.an & ~f.az;
            default: illegal = 1'b1;
        endcase
        return {cond, illegal};
    endfunction

endpackage

// File: rtl/comparer_flags.sv
// Combinational flag generation for comparer_pipe stage 1.
module comparer_flags
    import comparer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_flags_t       flags
);

    logic ult;

    always_comb begin
        ult       = (a < b);
        flags.eq  = (a == b);
        flags.ult = ult;
        // Differing signs: the negative operand is smaller; same signs: unsigned order holds.
        flags.slt = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : ult;
        flags.az  = (a == '0);
        flags.an  = a[WIDTH-1];
    end

endmodule

// File: rtl/comparer_pipe.sv
// Two-stage valid/ready branch/set condition comparer.
// Optional COMPARER_PIPE_STATS_EN adds saturating stat_taken / stat_stall counters.
module comparer_pipe
    import comparer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_ctrl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
`ifdef COMPARER_PIPE_STATS_EN
    ,
    output logic [31:0]      stat_taken,
    output logic [31:0]      stat_stall
`endif
);

    cmp_flags_t       flags;
    logic             adv1, adv2;
    logic [1:0]       dec;

    logic             s1_valid_q, s1_valid_d;
    cmp_flags_t       s1_flags_q, s1_flags_d;
    logic [2:0]       s1_ctrl_q, s1_ctrl_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_illegal_q, out_illegal_d;

    comparer_flags #(.WIDTH(WIDTH)) u_flags (
        .a     (in_a),
        .b     (in_b),
        .flags (flags)
    );

    assign adv2     = ~s2_valid_q | out_ready;
    assign adv1     = ~s1_valid_q | adv2;
    assign in_ready = adv1;
    assign dec      = cmp_decode(s1_ctrl_q, s1_flags_q);

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_flags_d    = s1_flags_q;
        s1_ctrl_d     = s1_ctrl_q;
        s1_tag_d      = s1_tag_q;
        s2_valid_d    = s2_valid_q;
        out_result_d  = out_result_q;
        out_tag_d     = out_tag_q;
        out_illegal_d = out_illegal_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_flags_d = flags;
                s1_ctrl_d  = in_ctrl;
                s1_tag_d   = in_tag;
            end
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d  = {{(WIDTH-1){1'b0}}, dec[1]};
                out_tag_d     = s1_tag_q;
                out_illegal_d = dec[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            out_result_q  <= '0;
            out_tag_q     <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s2_valid_q    <= s2_valid_d;
            out_result_q  <= out_result_d;
            out_tag_q     <= out_tag_d;
            out_illegal_q <= out_illegal_d;
        end
        s1_flags_q <= s1_flags_d;
        s1_ctrl_q  <= s1_ctrl_d;
        s1_tag_q   <= s1_tag_d;
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

`ifdef COMPARER_PIPE_STATS_EN
    logic [31:0] stat_taken_q, stat_taken_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_taken_d = stat_taken_q;
        stat_stall_d = stat_stall_q;
        if (s2_valid_q && out_ready && out_result_q[0] && (stat_taken_q != '1))
            stat_taken_d = stat_taken_q + 32'd1;
        if (s2_valid_q && !out_ready && (stat_stall_q != '1))
            stat_stall_d = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_taken_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_taken_q <= stat_taken_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_taken = stat_taken_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule
